// File: rtl/fpaddsub_pkg.sv
// Shared constants and the FIFO entry layout for the FP add/sub result path.
package fpaddsub_pkg;

   localparam int FP_W           = 32;
   localparam int FLG_W          = 5;
   localparam int ADDSUB_LATENCY = 10;

   localparam int FLG_OVF = 4;
   localparam int FLG_UNF = 3;
   localparam int FLG_DBZ = 2;
   localparam int FLG_INV = 1;
   localparam int FLG_INX = 0;

   localparam int ENTRY_W = FLG_W + FP_W;

   // Flags sit above the result so the packed entry reads {flags, result}.
   typedef struct packed {
      logic [FLG_W-1:0] flags;
      logic [FP_W-1:0]  result;
   } res_entry_t;

endpackage

// File: rtl/fpaddsub_result_buffer_if.sv
// Operation/result handshake between the adder environment and the result buffer.
interface fpaddsub_result_buffer_if;
   import fpaddsub_pkg::*;

   logic             op_valid_i;
   logic             op_ready_o;
   logic             issue_o;
   logic [FP_W-1:0]  add_result_i;
   logic [FLG_W-1:0] add_flags_i;
   logic             res_valid_o;
   logic             res_ready_i;
   logic [FP_W-1:0]  res_data_o;
   logic [FLG_W-1:0] res_flags_o;

   modport slave (
      input  op_valid_i, add_result_i, add_flags_i, res_ready_i,
      output op_ready_o, issue_o, res_valid_o, res_data_o, res_flags_o
   );

   modport master (
      output op_valid_i, add_result_i, add_flags_i, res_ready_i,
      input  op_ready_o, issue_o, res_valid_o, res_data_o, res_flags_o
   );

endinterface

// File: rtl/fpaddsub_sync_fifo.sv
// Registered FIFO with wrap-bit pointers; head is read straight from storage.
module fpaddsub_sync_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       din,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // A write into a full FIFO is only honoured when the head leaves in the same cycle.
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   always_ff @(posedge clk) begin
      if (do_wr)
         mem[wr_ptr[AW-1:0]] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_rd)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fpaddsub_result_buffer.sv
// Credit-based flow-control shell behind the non-stallable FP adder/subtractor:
// tracks in-flight ops, buffers results, and accumulates sticky exception flags.
module fpaddsub_result_buffer
   import fpaddsub_pkg::*;
#(
   parameter int LATENCY = ADDSUB_LATENCY,
   parameter int DEPTH   = 8,
   parameter int CW      = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   fpaddsub_result_buffer_if.slave  bus,
   output logic [FLG_W-1:0]         sticky_flags_o,
   input  logic                     flag_clear_i,
   output logic [CW-1:0]            inflight_o,
   output logic [CW-1:0]            count_o,
   output logic                     err_o
);

   logic [LATENCY-1:0]      vld_line;
   logic                    capture;
   logic                    issue;
   logic                    op_ready;
   logic                    pop;
   logic                    res_valid;
   logic [CW-1:0]           inflight;
   logic [CW-1:0]           credits_used;
   logic [ENTRY_W-1:0]      fifo_din;
   logic [ENTRY_W-1:0]      fifo_dout;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic [$clog2(DEPTH):0]  fifo_count;
   res_entry_t              head;

   // Every op in the adder or the FIFO holds a credit, so the FIFO can never overflow.
   assign credits_used = inflight + count_o;
   assign op_ready     = !rst && (credits_used < CW'(DEPTH));
   assign issue        = bus.op_valid_i && op_ready;
   assign capture      = vld_line[LATENCY-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_line <= '0;
      end else begin
         vld_line[0] <= issue;
         for (int i = 1; i < LATENCY; i++)
            vld_line[i] <= vld_line[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         inflight <= '0;
      else if (issue && !capture)
         inflight <= inflight + CW'(1);
      else if (!issue && capture)
         inflight <= inflight - CW'(1);
   end

   assign fifo_din = {bus.add_flags_i, bus.add_result_i};

   fpaddsub_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (capture),
      .din   (fifo_din),
      .rd_en (pop),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   assign head      = fifo_dout;
   assign res_valid = !fifo_empty;
   assign pop       = res_valid && bus.res_ready_i;

   // A capture in the same cycle as a clear is kept.
   always_ff @(posedge clk) begin
      if (rst)
         sticky_flags_o <= '0;
      else
         sticky_flags_o <= (flag_clear_i ? '0 : sticky_flags_o) | (capture ? bus.add_flags_i : '0);
   end

   always_ff @(posedge clk) begin
      if (rst)
         err_o <= 1'b0;
      else if ((capture && fifo_full && !pop) || (pop && fifo_empty))
         err_o <= 1'b1;
   end

   assign bus.op_ready_o  = op_ready;
   assign bus.issue_o     = issue;
   assign bus.res_valid_o = res_valid;
   assign bus.res_data_o  = head.result;
   assign bus.res_flags_o = head.flags;
   assign inflight_o      = inflight;
   assign count_o         = CW'(fifo_count);

endmodule
